// File: rtl/wb_crossbar_arbiter.sv
// Per-slave round-robin arbiter for the Wishbone crossbar.
// Produces a registered grant matrix and per-master allocation flags.
module wb_crossbar_arbiter #(
   parameter int NM = 2,
   parameter int NS = 2,
   localparam int NMW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NM-1:0]          i_cyc,
   input  logic [NM-1:0][NS-1:0]  i_request,
   output logic [NM-1:0][NS-1:0]  o_granted,
   output logic [NM-1:0]          o_m_allocated,
   output logic [NS-1:0]          o_s_allocated
);

   if (NM < 1) begin : g_bad_nm
      $error("wb_crossbar_arbiter: NM must be at least 1");
   end
   if (NS < 1) begin : g_bad_ns
      $error("wb_crossbar_arbiter: NS must be at least 1");
   end

   logic [NM-1:0][NS-1:0]  req;
   logic [NM-1:0][NS-1:0]  nxt_g;
   logic [NM-1:0]          row_busy;
   logic [NS-1:0][NMW-1:0] ptr;
   logic [NS-1:0][NMW-1:0] nxt_ptr;

   for (genvar m = 0; m < NM; m++) begin : g_row
      logic [NS-1:0] raw;
      assign raw = i_cyc[m] ? i_request[m] : '0;
      // isolate lowest set bit: illegal multi-hot falls back to lowest slave
      assign req[m] = raw & (~raw + NS'(1));
      assign row_busy[m] = |o_granted[m];
   end

   for (genvar s = 0; s < NS; s++) begin : g_slv
      logic           keep;
      logic           found;
      logic [NMW-1:0] win;
      int             idx;

      always_comb begin
         keep  = 1'b0;
         found = 1'b0;
         win   = ptr[s];
         idx   = 0;
         for (int m = 0; m < NM; m++) begin
            keep = keep | (o_granted[m][s] & req[m][s]);
         end
         for (int i = 1; i <= NM; i++) begin
            idx = (int'(ptr[s]) + i) % NM;
            if (!found && req[idx][s] && !row_busy[idx]) begin
               found = 1'b1;
               win   = NMW'(idx);
            end
         end
      end

      for (genvar m = 0; m < NM; m++) begin : g_bit
         assign nxt_g[m][s] = keep ? (o_granted[m][s] & req[m][s])
                                   : (found && (win == NMW'(m)));
      end

      assign nxt_ptr[s] = (!keep && found) ? win : ptr[s];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_granted     <= '0;
         o_m_allocated <= '0;
         for (int s = 0; s < NS; s++) begin
            ptr[s] <= NMW'(NM - 1);
         end
      end else begin
         o_granted     <= nxt_g;
         o_m_allocated <= row_busy;
         ptr           <= nxt_ptr;
      end
   end

   always_comb begin
      o_s_allocated = '0;
      for (int m = 0; m < NM; m++) begin
         o_s_allocated = o_s_allocated | o_granted[m];
      end
   end

endmodule

// File: tb/tb_wb_crossbar_arbiter.sv
// Scoreboard bench for wb_crossbar_arbiter (NM=4, NS=2).
// Directed vectors queue expectations; a monitor checks each cycle.
module tb_wb_crossbar_arbiter;

   logic             clk;
   logic             rst;
   logic [3:0]       cyc;
   logic [3:0][1:0]  req;
   logic [3:0][1:0]  granted;
   logic [3:0]       m_alloc;
   logic [1:0]       s_alloc;

   typedef struct {
      logic [7:0] g;
      logic [3:0] ma;
      logic [1:0] sa;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;
   int   vec_id;

   wb_crossbar_arbiter #(.NM(4), .NS(2)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_cyc         (cyc),
      .i_request     (req),
      .o_granted     (granted),
      .o_m_allocated (m_alloc),
      .o_s_allocated (s_alloc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [3:0] c,
                       input logic [7:0] rq, input logic [7:0] eg,
                       input logic [3:0] ema);
      exp_t e;
      @(negedge clk);
      rst = r;
      cyc = c;
      req = rq;
      e.g  = eg;
      e.ma = ema;
      e.sa[0] = eg[0] | eg[2] | eg[4] | eg[6];
      e.sa[1] = eg[1] | eg[3] | eg[5] | eg[7];
      e.id = vec_id;
      vec_id++;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (granted !== e.g) begin
            failures++;
            $display("FAIL granted v%0d: got %b want %b", e.id, granted, e.g);
         end
         checks++;
         if (m_alloc !== e.ma) begin
            failures++;
            $display("FAIL m_alloc v%0d: got %b want %b", e.id, m_alloc, e.ma);
         end
         checks++;
         if (s_alloc !== e.sa) begin
            failures++;
            $display("FAIL s_alloc v%0d: got %b want %b", e.id, s_alloc, e.sa);
         end
      end
   end

   initial begin
      checks = 0;
      failures = 0;
      vec_id = 0;
      rst = 1'b1;
      cyc = '0;
      req = '0;
      // reset with every master requesting s0
      step(1, 4'b1111, 8'b01010101, 8'b00000000, 4'b0000);
      step(1, 4'b1111, 8'b01010101, 8'b00000000, 4'b0000);
      step(0, 4'b1111, 8'b01010101, 8'b00000001, 4'b0000);
      // m0/m1 contention on s0 with direct handover
      step(0, 4'b0011, 8'b00000101, 8'b00000001, 4'b0001);
      step(0, 4'b0011, 8'b00000101, 8'b00000001, 4'b0001);
      step(0, 4'b0010, 8'b00000101, 8'b00000100, 4'b0001);
      step(0, 4'b0011, 8'b00000101, 8'b00000100, 4'b0010);
      step(0, 4'b0011, 8'b00000101, 8'b00000100, 4'b0010);
      step(0, 4'b0001, 8'b00000101, 8'b00000001, 4'b0010);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0001);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000);
      // pointer: m2, release, then m1+m3 -> m3
      step(0, 4'b0100, 8'b00010000, 8'b00010000, 4'b0000);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0100);
      step(0, 4'b1010, 8'b01000100, 8'b01000000, 4'b0000);
      step(0, 4'b1010, 8'b01000100, 8'b01000000, 4'b1000);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b1000);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000);
      // switch: m0 from s0 to s1 with CYC held
      step(0, 4'b0001, 8'b00000001, 8'b00000001, 4'b0000);
      step(0, 4'b0001, 8'b00000001, 8'b00000001, 4'b0001);
      step(0, 4'b0001, 8'b00000010, 8'b00000000, 4'b0001);
      step(0, 4'b0001, 8'b00000010, 8'b00000010, 4'b0000);
      step(0, 4'b0001, 8'b00000010, 8'b00000010, 4'b0001);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0001);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000);
      // parallel: m0->s1, m1->s0
      step(0, 4'b0011, 8'b00000110, 8'b00000110, 4'b0000);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0011);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000);
      // multi-hot m0 (11) keeps only s0; m1 takes s1
      step(0, 4'b0011, 8'b00001011, 8'b00001001, 4'b0000);
      step(0, 4'b0011, 8'b00001011, 8'b00001001, 4'b0011);
      // reset mid-operation drops everything
      step(1, 4'b0011, 8'b00001011, 8'b00000000, 4'b0000);
      step(0, 4'b0011, 8'b00001011, 8'b00001001, 4'b0000);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0011);
      step(0, 4'b0000, 8'b00000000, 8'b00000000, 4'b0000);
      @(negedge clk);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
